// File: rtl/mem_branch_unit_if.sv
// ---------------------------------------------------------------------------
// mem_branch_unit_if
// Bundle between the pipeline (master) and the MEM-stage branch resolution
// unit (slave).
//   Fetch lookup : lookup_pc_i -> lookup_taken_o (combinational prediction)
//   Resolve req  : valid_i, flush_i, branch_op_i, pc_i, target_i, rs1_i,
//                  rs2_i, pred_taken_i
//   Result       : res_valid_o, taken_o, mispredict_o, redirect_pc_o
//   Perf         : branch_cnt_o, mispredict_cnt_o
// Signal suffixes are from the point of view of the branch unit.
// ---------------------------------------------------------------------------
interface mem_branch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [31:0]            lookup_pc_i;
    logic                   lookup_taken_o;
    logic                   valid_i;
    logic                   flush_i;
    logic [2:0]             branch_op_i;
    logic [31:0]            pc_i;
    logic [31:0]            target_i;
    logic [DATA_WIDTH-1:0]  rs1_i;
    logic [DATA_WIDTH-1:0]  rs2_i;
    logic                   pred_taken_i;
    logic                   res_valid_o;
    logic                   taken_o;
    logic                   mispredict_o;
    logic [31:0]            redirect_pc_o;
    logic [CNT_WIDTH-1:0]   branch_cnt_o;
    logic [CNT_WIDTH-1:0]   mispredict_cnt_o;

    modport master (
        output lookup_pc_i, valid_i, flush_i, branch_op_i, pc_i, target_i,
               rs1_i, rs2_i, pred_taken_i,
        input  lookup_taken_o, res_valid_o, taken_o, mispredict_o,
               redirect_pc_o, branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  lookup_pc_i, valid_i, flush_i, branch_op_i, pc_i, target_i,
               rs1_i, rs2_i, pred_taken_i,
        output lookup_taken_o, res_valid_o, taken_o, mispredict_o,
               redirect_pc_o, branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/mem_branch_unit.sv
// ---------------------------------------------------------------------------
// mem_branch_unit
// MEM-stage branch resolution unit. Evaluates the RV32I branch conditions
// (EQ/NE/LT/GE/LTU/GEU) and unconditional jumps, trains a PC-indexed table
// of 2-bit saturating predictors, and returns a registered direction,
// mispredict flag and corrected next PC to fetch one cycle after accept.
// Ports:
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : mem_branch_unit_if.slave (lookup, resolve request, result, perf)
// Parameters:
//   DATA_WIDTH  : operand width (>= 8)
//   BHT_ENTRIES : predictor table entries, power of two, 2..1024
//   CNT_WIDTH   : width of the saturating perf counters
// ---------------------------------------------------------------------------
module mem_branch_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_branch_unit_if.slave  bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_EQ   = 3'd1,
        OP_NE   = 3'd2,
        OP_LT   = 3'd3,
        OP_GE   = 3'd4,
        OP_LTU  = 3'd5,
        OP_GEU  = 3'd6,
        OP_JUMP = 3'd7
    } branch_op_e;

    // 2-bit predictor counter steps, saturating at both ends.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Perf counter step, sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Predictor table
    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] train_idx;
    logic             lookup_pc_unused;

    assign lookup_idx = bus.lookup_pc_i[IDX_W+1:2];
    assign train_idx  = bus.pc_i[IDX_W+1:2];
    // Only the index bits of the lookup PC matter.
    assign lookup_pc_unused = ^{bus.lookup_pc_i[31:IDX_W+2], bus.lookup_pc_i[1:0]};

    // Reads the registered table, so a same-cycle train is not visible yet.
    assign bus.lookup_taken_o = bht[lookup_idx][1];

    // ---- stage p0: condition evaluation -----------------------------------
    branch_op_e                    op_p0;
    logic signed [DATA_WIDTH-1:0]  rs1_s_p0;
    logic signed [DATA_WIDTH-1:0]  rs2_s_p0;
    logic                          accept_p0;
    logic                          is_cond_p0;
    logic                          taken_p0;
    logic                          mispredict_p0;
    logic [31:0]                   redirect_p0;

    assign op_p0     = branch_op_e'(bus.branch_op_i);
    assign rs1_s_p0  = bus.rs1_i;
    assign rs2_s_p0  = bus.rs2_i;
    // flush wins over valid; NONE is never accepted.
    assign accept_p0 = bus.valid_i & ~bus.flush_i & (op_p0 != OP_NONE);

    always_comb begin
        taken_p0   = 1'b0;
        is_cond_p0 = 1'b1;
        case (op_p0)
            OP_EQ:   taken_p0 = (bus.rs1_i == bus.rs2_i);
            OP_NE:   taken_p0 = (bus.rs1_i != bus.rs2_i);
            OP_LT:   taken_p0 = (rs1_s_p0 <  rs2_s_p0);
            OP_GE:   taken_p0 = (rs1_s_p0 >= rs2_s_p0);
            OP_LTU:  taken_p0 = (bus.rs1_i <  bus.rs2_i);
            OP_GEU:  taken_p0 = (bus.rs1_i >= bus.rs2_i);
            OP_JUMP: begin
                taken_p0   = 1'b1;
                is_cond_p0 = 1'b0;
            end
            default: begin
                taken_p0   = 1'b0;
                is_cond_p0 = 1'b0;
            end
        endcase
    end

    assign mispredict_p0 = taken_p0 ^ bus.pred_taken_i;
    // Fall-through wraps modulo 2^32.
    assign redirect_p0   = taken_p0 ? bus.target_i : bus.pc_i + 32'd4;

    // ---- predictor training -----------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept_p0 && is_cond_p0) begin
            bht[train_idx] <= taken_p0 ? ctr_inc(bht[train_idx])
                                       : ctr_dec(bht[train_idx]);
        end
    end

    // ---- stage p1: registered result --------------------------------------
    logic        vld_p1;
    logic        taken_p1;
    logic        mispredict_p1;
    logic [31:0] redirect_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1        <= 1'b0;
            taken_p1      <= 1'b0;
            mispredict_p1 <= 1'b0;
            redirect_p1   <= 32'd0;
        end else begin
            vld_p1 <= accept_p0;
            // Result fields hold until the next accepted request.
            if (accept_p0) begin
                taken_p1      <= taken_p0;
                mispredict_p1 <= mispredict_p0;
                redirect_p1   <= redirect_p0;
            end
        end
    end

    assign bus.res_valid_o   = vld_p1;
    assign bus.taken_o       = taken_p1;
    assign bus.mispredict_o  = mispredict_p1;
    assign bus.redirect_pc_o = redirect_p1;

    // ---- performance counters ---------------------------------------------
    logic [CNT_WIDTH-1:0] branch_cnt_r;
    logic [CNT_WIDTH-1:0] mispredict_cnt_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_r     <= '0;
            mispredict_cnt_r <= '0;
        end else if (accept_p0) begin
            branch_cnt_r <= cnt_sat_inc(branch_cnt_r);
            if (mispredict_p0) begin
                mispredict_cnt_r <= cnt_sat_inc(mispredict_cnt_r);
            end
        end
    end

    assign bus.branch_cnt_o     = branch_cnt_r;
    assign bus.mispredict_cnt_o = mispredict_cnt_r;

endmodule

// File: tb/tb_mem_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_branch_unit
// Directed bench for mem_branch_unit. A second instance with CNT_WIDTH=4
// mirrors the main stimulus to exercise perf-counter saturation.
// ---------------------------------------------------------------------------
module tb_mem_branch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_branch_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();
    mem_branch_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  bus4 ();

    mem_branch_unit #(.DATA_WIDTH(32), .BHT_ENTRIES(16), .CNT_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    mem_branch_unit #(.DATA_WIDTH(32), .BHT_ENTRIES(16), .CNT_WIDTH(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    assign bus4.lookup_pc_i  = bus.lookup_pc_i;
    assign bus4.valid_i      = bus.valid_i;
    assign bus4.flush_i      = bus.flush_i;
    assign bus4.branch_op_i  = bus.branch_op_i;
    assign bus4.pc_i         = bus.pc_i;
    assign bus4.target_i     = bus.target_i;
    assign bus4.rs1_i        = bus.rs1_i;
    assign bus4.rs2_i        = bus.rs2_i;
    assign bus4.pred_taken_i = bus.pred_taken_i;

    localparam logic [2:0] NONE = 3'd0, EQ = 3'd1, NE = 3'd2, LT = 3'd3,
                           GE = 3'd4, LTU = 3'd5, GEU = 3'd6, JUMP = 3'd7;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_i      = 1'b0;
        bus.flush_i      = 1'b0;
        bus.branch_op_i  = NONE;
        bus.pc_i         = 32'd0;
        bus.target_i     = 32'd0;
        bus.rs1_i        = 32'd0;
        bus.rs2_i        = 32'd0;
        bus.pred_taken_i = 1'b0;
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
        bus.valid_i      = 1'b1;
        bus.flush_i      = 1'b0;
        bus.branch_op_i  = op;
        bus.pc_i         = pc;
        bus.target_i     = tgt;
        bus.rs1_i        = a;
        bus.rs2_i        = b;
        bus.pred_taken_i = pred;
    endtask

    task automatic result(input string tag, input logic tk, input logic mis, input logic [31:0] rd);
        check({tag, "_vld"},   bus.res_valid_o,   1'b1);
        check({tag, "_taken"}, bus.taken_o,       tk);
        check({tag, "_mis"},   bus.mispredict_o,  mis);
        check({tag, "_rdir"},  bus.redirect_pc_o, rd);
    endtask

    initial begin
        idle();
        bus.lookup_pc_i = 32'h100;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_lookup",  bus.lookup_taken_o,   1'b0);
        check("rst_vld",     bus.res_valid_o,      1'b0);
        check("rst_taken",   bus.taken_o,          1'b0);
        check("rst_mis",     bus.mispredict_o,     1'b0);
        check("rst_rdir",    bus.redirect_pc_o,    32'h0);
        check("rst_bcnt",    bus.branch_cnt_o,     32'd0);
        check("rst_mcnt",    bus.mispredict_cnt_o, 32'd0);
        check("rst_bcnt4",   bus4.branch_cnt_o,    4'd0);

        // EQ taken, predicted not-taken
        req(EQ, 32'h100, 32'h140, 32'd5, 32'd5, 1'b0);
        tick();
        idle();
        result("eq", 1'b1, 1'b1, 32'h140);
        check("eq_bcnt",   bus.branch_cnt_o,     32'd1);
        check("eq_mcnt",   bus.mispredict_cnt_o, 32'd1);
        check("eq_lookup", bus.lookup_taken_o,   1'b1);
        tick();
        check("eq_pulse_end", bus.res_valid_o,   1'b0);
        check("eq_hold_rdir", bus.redirect_pc_o, 32'h140);

        // Signed vs unsigned compares, back-to-back
        req(LT, 32'h210, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tick();
        result("lt", 1'b1, 1'b0, 32'h300);
        req(LTU, 32'h214, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        result("ltu", 1'b0, 1'b0, 32'h218);
        req(GE, 32'h218, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        result("ge", 1'b0, 1'b0, 32'h21C);
        req(GEU, 32'h21C, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tick();
        idle();
        result("geu", 1'b1, 1'b1, 32'h300);
        check("cmp_bcnt", bus.branch_cnt_o,     32'd5);
        check("cmp_mcnt", bus.mispredict_cnt_o, 32'd2);

        // Predictor saturation at entry 1 (pc 0x104, aliased by 0x144)
        bus.lookup_pc_i = 32'h104;
        for (int i = 0; i < 4; i++) begin
            req(EQ, 32'h104, 32'h400, 32'd3, 32'd3, 1'b1);
            tick();
        end
        check("sat3_lookup", bus.lookup_taken_o, 1'b1);
        req(NE, 32'h104, 32'h400, 32'd3, 32'd3, 1'b0);
        tick();
        check("dec1_lookup", bus.lookup_taken_o, 1'b1);
        tick();
        check("dec2_lookup", bus.lookup_taken_o, 1'b0);
        tick();
        tick();
        tick();
        check("sat0_lookup", bus.lookup_taken_o, 1'b0);
        req(EQ, 32'h144, 32'h400, 32'd9, 32'd9, 1'b0);
        tick();
        check("alias1_lookup", bus.lookup_taken_o, 1'b0);
        tick();
        idle();
        check("alias2_lookup", bus.lookup_taken_o, 1'b1);
        check("train_bcnt", bus.branch_cnt_o,     32'd16);
        check("train_mcnt", bus.mispredict_cnt_o, 32'd4);

        // Same-cycle lookup and training of entry 2
        bus.lookup_pc_i = 32'h108;
        req(EQ, 32'h108, 32'h180, 32'd1, 32'd1, 1'b0);
        #1;
        check("same_pre", bus.lookup_taken_o, 1'b0);
        tick();
        idle();
        check("same_post", bus.lookup_taken_o, 1'b1);

        // Flush and NONE are ignored
        bus.lookup_pc_i = 32'h10C;
        req(EQ, 32'h10C, 32'h600, 32'd2, 32'd2, 1'b0);
        bus.flush_i = 1'b1;
        tick();
        check("flush_vld",    bus.res_valid_o,    1'b0);
        check("flush_hold",   bus.redirect_pc_o,  32'h180);
        check("flush_lookup", bus.lookup_taken_o, 1'b0);
        req(NONE, 32'h10C, 32'h600, 32'd2, 32'd2, 1'b0);
        tick();
        idle();
        check("none_vld",  bus.res_valid_o,  1'b0);
        check("none_bcnt", bus.branch_cnt_o, 32'd17);

        // Fall-through wrap and a non-training JUMP
        req(NE, 32'hFFFF_FFFC, 32'h40, 32'd7, 32'd7, 1'b0);
        tick();
        result("wrap", 1'b0, 1'b0, 32'h0);
        req(JUMP, 32'h10C, 32'h500, 32'd0, 32'd0, 1'b0);
        tick();
        idle();
        result("jump", 1'b1, 1'b1, 32'h500);
        check("jump_notrain", bus.lookup_taken_o,   1'b0);
        check("jump_bcnt",    bus.branch_cnt_o,     32'd19);
        check("jump_mcnt",    bus.mispredict_cnt_o, 32'd6);
        check("sat_bcnt4",    bus4.branch_cnt_o,    4'd15);

        // Reset while a request is presented
        bus.lookup_pc_i = 32'h104;
        req(EQ, 32'h104, 32'h700, 32'd1, 32'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("rreq_vld",    bus.res_valid_o,    1'b0);
        check("rreq_bcnt",   bus.branch_cnt_o,   32'd0);
        check("rreq_rdir",   bus.redirect_pc_o,  32'h0);
        check("rreq_lookup", bus.lookup_taken_o, 1'b0);
        tick();
        check("rreq_nopulse", bus.res_valid_o, 1'b0);

        // 17 mispredicting jumps: 4-bit counters stick at 15
        for (int i = 0; i < 17; i++) begin
            req(JUMP, 32'h800, 32'h900, 32'd0, 32'd0, 1'b0);
            tick();
        end
        idle();
        check("b2b_vld",   bus.res_valid_o,       1'b1);
        check("cnt_bcnt",  bus.branch_cnt_o,      32'd17);
        check("cnt_mcnt",  bus.mispredict_cnt_o,  32'd17);
        check("cnt_bcnt4", bus4.branch_cnt_o,     4'd15);
        check("cnt_mcnt4", bus4.mispredict_cnt_o, 4'd15);
        tick();
        check("final_vld", bus.res_valid_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
